// File: rtl/booth_mac_accumulator.sv
// Three-stage multiply-accumulate wrapper around an external combinational Booth multiplier.
// Optional build macro MAC_SATURATE_EN clamps the accumulator on signed overflow and reports it on out_sat.
module booth_mac_accumulator #(
   parameter int ACC_W = 72,
   parameter int CNT_W = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [31:0]             in_a,
   input  logic [31:0]             in_b,
   input  logic                    in_last,
   output logic [31:0]             mul_a,
   output logic [31:0]             mul_b,
   input  logic [63:0]             mul_p,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [ACC_W-1:0]        out_acc,
   output logic [CNT_W-1:0]        out_count,
   output logic                    out_sat
);

   logic                    stall;
   logic                    accept;
   logic                    s1_valid;
   logic                    s1_last;
   logic                    s2_valid;
   logic                    s2_last;
   logic signed [63:0]      p_reg;
   logic signed [ACC_W-1:0] acc;
   logic [CNT_W-1:0]        count;
   logic signed [ACC_W-1:0] p_ext;
   logic signed [ACC_W-1:0] sum_raw;
   logic signed [ACC_W-1:0] sum;
   logic                    overflow;
   logic [CNT_W-1:0]        cnt_next;
   logic                    s3_fire;

   // A held result that the consumer refuses freezes the whole pipe.
   assign stall    = out_valid & ~out_ready;
   assign in_ready = ~stall;
   assign accept   = in_valid & in_ready;
   assign s3_fire  = ~stall & s2_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_last  <= 1'b0;
         mul_a    <= '0;
         mul_b    <= '0;
      end else if (!stall) begin
         s1_valid <= accept;
         s1_last  <= accept & in_last;
         if (accept) begin
            mul_a <= in_a;
            mul_b <= in_b;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid <= 1'b0;
         s2_last  <= 1'b0;
         p_reg    <= '0;
      end else if (!stall) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            p_reg   <= $signed(mul_p);
            s2_last <= s1_last;
         end
      end
   end

   always_comb begin
      p_ext    = ACC_W'(p_reg);
      sum_raw  = acc + p_ext;
      overflow = (acc[ACC_W-1] == p_ext[ACC_W-1]) && (sum_raw[ACC_W-1] != acc[ACC_W-1]);
      sum      = sum_raw;
`ifdef MAC_SATURATE_EN
      if (overflow) begin
         sum = acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end
`endif
      cnt_next = (&count) ? count : count + CNT_W'(1);
   end

   // The accumulator restarts from zero on the same edge a finished sum is published.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc       <= '0;
         count     <= '0;
         out_acc   <= '0;
         out_count <= '0;
         out_valid <= 1'b0;
      end else begin
         if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
         if (s3_fire) begin
            if (s2_last) begin
               out_acc   <= sum;
               out_count <= cnt_next;
               out_valid <= 1'b1;
               acc       <= '0;
               count     <= '0;
            end else begin
               acc   <= sum;
               count <= cnt_next;
            end
         end
      end
   end

`ifdef MAC_SATURATE_EN
   logic sat_flag;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sat_flag <= 1'b0;
         out_sat  <= 1'b0;
      end else if (s3_fire) begin
         if (s2_last) begin
            out_sat  <= sat_flag | overflow;
            sat_flag <= 1'b0;
         end else begin
            sat_flag <= sat_flag | overflow;
         end
      end
   end
`else
   assign out_sat = 1'b0;
`endif

endmodule

// File: tb/tb_booth_mac_accumulator.sv
// Directed self-checking bench for booth_mac_accumulator: a 72-bit and a 64-bit instance share stimulus.
// Expected saturation behaviour of the 64-bit instance follows the MAC_SATURATE_EN macro.
module tb_booth_mac_accumulator;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [31:0] in_a = '0;
   logic [31:0] in_b = '0;
   logic        in_last = 1'b0;
   logic        out_ready = 1'b1;

   logic        in_ready, out_valid, out_sat;
   logic [31:0] mul_a, mul_b;
   logic [63:0] mul_p;
   logic [71:0] out_acc;
   logic [15:0] out_count;

   logic        in_ready64, out_valid64, out_sat64;
   logic [31:0] mul_a64, mul_b64;
   logic [63:0] mul_p64;
   logic [63:0] out_acc64;
   logic [15:0] out_count64;

   int checks = 0;
   int errors = 0;
   int edges;

   always #5 clk = ~clk;

   // Behavioural stand-in for the combinational Booth multiplier.
   logic signed [63:0] ea, eb, ea64, eb64;
   assign ea      = $signed(mul_a);
   assign eb      = $signed(mul_b);
   assign mul_p   = ea * eb;
   assign ea64    = $signed(mul_a64);
   assign eb64    = $signed(mul_b64);
   assign mul_p64 = ea64 * eb64;

   booth_mac_accumulator #(.ACC_W(72), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_last(in_last),
      .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_acc(out_acc), .out_count(out_count), .out_sat(out_sat)
   );

   booth_mac_accumulator #(.ACC_W(64), .CNT_W(16)) dut64 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64),
      .in_a(in_a), .in_b(in_b), .in_last(in_last),
      .mul_a(mul_a64), .mul_b(mul_b64), .mul_p(mul_p64),
      .out_valid(out_valid64), .out_ready(out_ready),
      .out_acc(out_acc64), .out_count(out_count64), .out_sat(out_sat64)
   );

   task automatic checkOutput(input string tag, input logic [71:0] observed, input logic [71:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents one term and consumes exactly one edge; callers only use it while in_ready is high.
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic last);
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_last  = last;
      step();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // Edge count includes the edge that accepted the last term.
   task automatic waitResult(output int n);
      n = 1;
      while (!out_valid && n < 12) begin
         step();
         n++;
      end
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // reset state
      #3;
      checkOutput("rst_in_ready", in_ready, 1);
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_out_acc", out_acc, 0);
      checkOutput("rst_out_count", out_count, 0);
      checkOutput("rst_out_sat", out_sat, 0);
      checkOutput("rst_mul_a", mul_a, 0);
      step();
      rst = 1'b0;
      step();

      // (3,4) + (-2,5) = 2
      applyStimulus(32'd3, 32'd4, 1'b0);
      applyStimulus(-32'sd2, 32'd5, 1'b1);
      waitResult(edges);
      checkOutput("t1_latency", edges, 3);
      checkOutput("t1_acc", out_acc, 72'd2);
      checkOutput("t1_count", out_count, 16'd2);
      checkOutput("t1_acc64", out_acc64, 72'd2);
      step();
      checkOutput("t1_valid_clear", out_valid, 0);

      // largest positive square
      applyStimulus(32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1);
      waitResult(edges);
      checkOutput("t2_acc", out_acc, 72'h3FFFFFFF00000001);
      checkOutput("t2_count", out_count, 16'd1);
      checkOutput("t2_acc64", out_acc64, 72'h3FFFFFFF00000001);
      step();

      // most negative square
      applyStimulus(32'h80000000, 32'h80000000, 1'b1);
      waitResult(edges);
      checkOutput("t3_acc", out_acc, 72'h4000000000000000);
      checkOutput("t3_count", out_count, 16'd1);
      step();

      // two most-negative squares overflow a 64-bit accumulator but not a 72-bit one
      applyStimulus(32'h80000000, 32'h80000000, 1'b0);
      applyStimulus(32'h80000000, 32'h80000000, 1'b1);
      waitResult(edges);
      checkOutput("t4_acc72", out_acc, 72'h008000000000000000);
      checkOutput("t4_sat72", out_sat, 0);
      checkOutput("t4_count64", out_count64, 16'd2);
`ifdef MAC_SATURATE_EN
      checkOutput("t4_acc64", out_acc64, 72'h7FFFFFFFFFFFFFFF);
      checkOutput("t4_sat64", out_sat64, 1);
`else
      checkOutput("t4_acc64", out_acc64, 72'h8000000000000000);
      checkOutput("t4_sat64", out_sat64, 0);
`endif
      step();

      // sticky saturation flag must not leak into the next dot product
      applyStimulus(32'd1, 32'd1, 1'b1);
      waitResult(edges);
      checkOutput("t5_acc64", out_acc64, 72'd1);
      checkOutput("t5_sat64", out_sat64, 0);
      step();

      // back-to-back one-term products under backpressure
      out_ready = 1'b0;
      applyStimulus(32'd2, 32'd3, 1'b1);
      applyStimulus(32'd4, 32'd5, 1'b1);
      step();
      checkOutput("t6_first_valid", out_valid, 1);
      checkOutput("t6_first_acc", out_acc, 72'd6);
      for (int i = 0; i < 3; i++) step();
      checkOutput("t6_hold_acc", out_acc, 72'd6);
      checkOutput("t6_hold_count", out_count, 16'd1);
      checkOutput("t6_in_ready_low", in_ready, 0);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      checkOutput("t6_second_valid", out_valid, 1);
      checkOutput("t6_second_acc", out_acc, 72'd20);
      checkOutput("t6_second_count", out_count, 16'd1);
      step();
      step();
      checkOutput("t6_second_hold", out_acc, 72'd20);
      out_ready = 1'b1;
      step();
      checkOutput("t6_drained", out_valid, 0);
      step();
      step();
      checkOutput("t6_no_duplicate", out_valid, 0);

      // reset discards a partial sum
      applyStimulus(32'd10, 32'd10, 1'b0);
      applyStimulus(32'd11, 32'd11, 1'b0);
      rst = 1'b1;
      #1;
      checkOutput("t7_rst_in_ready", in_ready, 1);
      checkOutput("t7_rst_out_acc", out_acc, 0);
      checkOutput("t7_rst_out_count", out_count, 0);
      checkOutput("t7_rst_mul_a", mul_a, 0);
      checkOutput("t7_rst_mul_b", mul_b, 0);
      checkOutput("t7_rst_out_valid", out_valid, 0);
      step();
      rst = 1'b0;
      step();
      applyStimulus(32'd7, 32'd7, 1'b1);
      waitResult(edges);
      checkOutput("t7_latency", edges, 3);
      checkOutput("t7_acc", out_acc, 72'd49);
      checkOutput("t7_count", out_count, 16'd1);
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
